// File: rtl/bip_program_loader.sv
`timescale 1ns/1ps
// bip_program_loader: writer side of the BIP I instruction path.
// Packs pairs of UART bytes into 16-bit instruction words, writes them
// sequentially into program memory and holds the CPU in reset until a HALT
// word (opcode 5'b00000) has been stored.
// Optional feature: define BIP_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte after the HALT word before the load is accepted.
module bip_program_loader #(
  parameter int unsigned PM_ADDR_W = 11,
  parameter int unsigned INSTR_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 pm_wr_en,
  output logic [PM_ADDR_W-1:0] pm_addr,
  output logic [INSTR_W-1:0]   pm_wr_data,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error,
  output logic [PM_ADDR_W:0]   prog_len
);

  // An instruction word is always exactly two UART bytes.
  if (INSTR_W != 16) begin : g_bad_instr_w
    $error("bip_program_loader: INSTR_W must be 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
`ifdef BIP_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           hi_q, hi_d;
  logic [PM_ADDR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0]   wdata_q, wdata_d;
  logic [PM_ADDR_W:0]   len_q, len_d;

  logic is_halt;
  logic addr_full;
  logic wr_continues;

  assign is_halt      = (wdata_q[INSTR_W-1 -: 5] == 5'b00000);
  assign addr_full    = (addr_q == '1);
  // A write that neither stores HALT nor fills memory keeps the load going,
  // so a byte arriving in that same cycle is the next high byte.
  assign wr_continues = !is_halt && !addr_full;

`ifdef BIP_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       byte_acc;

  // Flags every data byte that enters an instruction word.
  always_comb begin
    byte_acc = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_HI, S_LO: byte_acc = 1'b1;
        S_WR:       byte_acc = wr_continues;
        default:    byte_acc = 1'b0;
      endcase
    end
  end

  // Running XOR of accepted data bytes, cleared by start.
  always_comb begin
    csum_d = csum_q;
    if (start) begin
      csum_d = '0;
    end else if (byte_acc) begin
      csum_d = csum_q ^ rx_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start overrides everything, including a same-cycle byte.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_HI;
    end else begin
      case (state_q)
        S_HI: begin
          if (rx_valid) state_d = S_LO;
        end
        S_LO: begin
          if (rx_valid) state_d = S_WR;
        end
        S_WR: begin
          if (is_halt) begin
`ifdef BIP_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if (addr_full) begin
            state_d = S_ERR;
          end else if (rx_valid) begin
            state_d = S_LO;
          end else begin
            state_d = S_HI;
          end
        end
`ifdef BIP_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values: high byte, address, word and length.
  always_comb begin
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    if (start) begin
      addr_d = '0;
      len_d  = '0;
    end else begin
      case (state_q)
        S_HI: begin
          if (rx_valid) hi_d = rx_data;
        end
        S_LO: begin
          if (rx_valid) wdata_d = {hi_q, rx_data};
        end
        S_WR: begin
          len_d = len_q + 1'b1;
          if (wr_continues) begin
            addr_d = addr_q + 1'b1;
            if (rx_valid) hi_d = rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
    end else begin
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    pm_wr_en   = (state_q == S_WR);
    cpu_hold   = (state_q != S_DONE);
    load_done  = (state_q == S_DONE);
    load_error = (state_q == S_ERR);
  end

  assign pm_addr    = addr_q;
  assign pm_wr_data = wdata_q;
  assign prog_len   = len_q;

endmodule

// File: tb/tb_bip_program_loader.sv
`timescale 1ns/1ps
// Bench for bip_program_loader: a default-size instance and a 4-word
// instance share one stimulus stream; expected writes are queued per
// instance and popped by a monitor whenever pm_wr_en is seen.
module tb_bip_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;

  logic        b_wr_en, b_hold, b_done, b_err;
  logic [10:0] b_addr;
  logic [15:0] b_data;
  logic [11:0] b_len;

  logic        s_wr_en, s_hold, s_done, s_err;
  logic [1:0]  s_addr;
  logic [15:0] s_data;
  logic [2:0]  s_len;

  bip_program_loader dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_wr_en(b_wr_en), .pm_addr(b_addr), .pm_wr_data(b_data), .cpu_hold(b_hold),
    .load_done(b_done), .load_error(b_err), .prog_len(b_len)
  );

  bip_program_loader #(.PM_ADDR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_wr_en(s_wr_en), .pm_addr(s_addr), .pm_wr_data(s_data), .cpu_hold(s_hold),
    .load_done(s_done), .load_error(s_err), .prog_len(s_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t q_b[$];
  wr_t q_s[$];

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void exp_b(input int unsigned a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q_b.push_back(e);
  endfunction

  function automatic void exp_s(input int unsigned a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    q_s.push_back(e);
  endfunction

  function automatic void exp_both(input int unsigned a, input logic [15:0] d);
    exp_b(a, d);
    exp_s(a, d);
  endfunction

  // Monitor: every observed write must match the head of the expectation queue.
  always @(negedge clk) begin : mon_b
    wr_t e;
    if (b_wr_en !== 1'b0) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL big_unexpected_write: got addr=0x%0h data=0x%0h expected no write", b_addr, b_data);
      end else begin
        e = q_b.pop_front();
        check("big_wr_addr", 32'(b_addr), e.addr);
        check("big_wr_data", 32'(b_data), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_s
    wr_t e;
    if (s_wr_en !== 1'b0) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected_write: got addr=0x%0h data=0x%0h expected no write", s_addr, s_data);
      end else begin
        e = q_s.pop_front();
        check("small_wr_addr", 32'(s_addr), e.addr);
        check("small_wr_data", 32'(s_data), 32'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  // Byte with no idle cycle after it.
  task automatic send_raw(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(b);
    tick();
  endtask

  task automatic status_b(input string tag, input logic done_e, input logic hold_e,
                          input logic err_e, input int unsigned len_e);
    check({tag, "_big_load_done"}, 32'(b_done), 32'(done_e));
    check({tag, "_big_cpu_hold"}, 32'(b_hold), 32'(hold_e));
    check({tag, "_big_load_error"}, 32'(b_err), 32'(err_e));
    check({tag, "_big_prog_len"}, 32'(b_len), len_e);
  endtask

  task automatic status_s(input string tag, input logic done_e, input logic hold_e,
                          input logic err_e, input int unsigned len_e);
    check({tag, "_small_load_done"}, 32'(s_done), 32'(done_e));
    check({tag, "_small_cpu_hold"}, 32'(s_hold), 32'(hold_e));
    check({tag, "_small_load_error"}, 32'(s_err), 32'(err_e));
    check({tag, "_small_prog_len"}, 32'(s_len), len_e);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_big_wr_en"}, 32'(b_wr_en), 32'd0);
    check({tag, "_big_addr"}, 32'(b_addr), 32'd0);
    check({tag, "_big_data"}, 32'(b_data), 32'd0);
    check({tag, "_small_wr_en"}, 32'(s_wr_en), 32'd0);
    check({tag, "_small_addr"}, 32'(s_addr), 32'd0);
    check({tag, "_small_data"}, 32'(s_data), 32'd0);
    status_b(tag, 1'b0, 1'b1, 1'b0, 0);
    status_s(tag, 1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    // Reset values while rst_n is held low.
    tick();
    tick();
    reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Basic load: 0x1805, 0x2803, HALT.
    pulse_start();
    exp_both(0, 16'h1805);
    exp_both(1, 16'h2803);
    exp_both(2, 16'h0000);
    send(8'h18); send(8'h05);
    send(8'h28); send(8'h03);
    send(8'h00); send(8'h00);
`ifdef BIP_LOADER_CHECKSUM_EN
    send(8'h36);
`endif
    tick(); tick();
    status_b("basic", 1'b1, 1'b0, 1'b0, 3);
    status_s("basic", 1'b1, 1'b0, 1'b0, 3);

`ifdef BIP_LOADER_CHECKSUM_EN
    // Same stream, wrong checksum byte.
    pulse_start();
    exp_both(0, 16'h1805);
    exp_both(1, 16'h2803);
    exp_both(2, 16'h0000);
    send(8'h18); send(8'h05);
    send(8'h28); send(8'h03);
    send(8'h00); send(8'h00);
    send(8'h37);
    tick(); tick();
    status_b("csum_bad", 1'b0, 1'b1, 1'b1, 3);
    status_s("csum_bad", 1'b0, 1'b1, 1'b1, 3);
`endif

    // Overflow: four non-HALT words fill the 4-word memory.
    pulse_start();
    for (int unsigned i = 0; i < 4; i++) begin
      exp_both(i, 16'h1801 + 16'(i));
      send(8'h18);
      send(8'h01 + 8'(i));
    end
    tick(); tick();
    status_s("ovf", 1'b0, 1'b1, 1'b1, 4);
    status_b("ovf", 1'b0, 1'b1, 1'b0, 4);
    exp_b(4, 16'h1805);
    send(8'h18); send(8'h05);
    tick(); tick();
    status_s("ovf_after", 1'b0, 1'b1, 1'b1, 4);
    status_b("ovf_after", 1'b0, 1'b1, 1'b0, 5);

    // Back-to-back: high byte of word 1 arrives during the write of word 0.
    pulse_start();
    exp_both(0, 16'h1805);
    exp_both(1, 16'h2007);
    exp_both(2, 16'h0000);
    send(8'h18);
    send_raw(8'h05);
    send_raw(8'h20);
    send(8'h07);
    send(8'h00); send(8'h00);
`ifdef BIP_LOADER_CHECKSUM_EN
    send(8'h3A);
`endif
    tick(); tick();
    status_b("b2b", 1'b1, 1'b0, 1'b0, 3);
    status_s("b2b", 1'b1, 1'b0, 1'b0, 3);

    // Restart mid-word: partial 0x28 discarded, HALT rewritten at addr 0.
    pulse_start();
    exp_both(0, 16'h1805);
    send(8'h18); send(8'h05); send(8'h28);
    pulse_start();
    exp_both(0, 16'h0000);
    send(8'h00); send(8'h00);
`ifdef BIP_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    tick(); tick();
    status_b("restart", 1'b1, 1'b0, 1'b0, 1);
    status_s("restart", 1'b1, 1'b0, 1'b0, 1);

    // Asynchronous reset mid-load, checked before the next clock edge.
    pulse_start();
    exp_both(0, 16'h1805);
    send(8'h18); send(8'h05); send(8'h28);
    #1 rst_n = 1'b0;
    #1 reset_vals("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h18); send(8'h05);
    send(8'h00); send(8'h00);
    tick(); tick();
    status_b("post_rst", 1'b0, 1'b1, 1'b0, 0);
    status_s("post_rst", 1'b0, 1'b1, 1'b0, 0);

    // Every expected write must have been consumed.
    check("big_pending_writes", q_b.size(), 32'd0);
    check("small_pending_writes", q_s.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
